// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode encodings: NOP word, pc_sel redirect sources, fetch FSM states, opcodes.
package fetch_unit_pkg;

    localparam logic [15:0] NOP_INST = 16'h0000;

    typedef enum logic [1:0] {
        PCSEL_SEQ = 2'b00,
        PCSEL_BR  = 2'b01,
        PCSEL_JMP = 2'b10,
        PCSEL_RET = 2'b11
    } pc_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    // Major opcodes in inst[15:12], shared with the decoder.
    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_ALU    = 4'h1;
    localparam logic [3:0] OP_LOAD   = 4'h2;
    localparam logic [3:0] OP_STORE  = 4'h3;
    localparam logic [3:0] OP_BRANCH = 4'h4;
    localparam logic [3:0] OP_JUMP   = 4'h5;
    localparam logic [3:0] OP_RET    = 4'h6;

    function automatic logic is_redirect(input logic taken, input logic [1:0] sel);
        return taken && (sel != PCSEL_SEQ);
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry inst+pc holding register for a word that arrives while IF/ID is stalled.
// Load sets valid; unload or clear empties it; load wins if both occur.
module fetch_skid_buffer
    import fetch_unit_pkg::*;
#(
    parameter int XLEN = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            unload,
    input  logic            clear,
    input  logic [XLEN-1:0] in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic [XLEN-1:0] buf_inst,
    output logic [XLEN-1:0] buf_pc,
    output logic            buf_valid
);

    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;

    always_comb begin
        inst_d  = inst_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (load) begin
            inst_d  = in_inst;
            pc_d    = in_pc;
            valid_d = 1'b1;
        end else if (clear || unload) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_q  <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign buf_inst  = inst_q;
    assign buf_pc    = pc_q;
    assign buf_valid = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, single-outstanding imem req/ready, 1-cycle pc->IF/ID latency.
// Stall holds IF/ID (a landed word is skidded); redirect squashes to NOP and drains any orphan request.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN     = 16,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [1:0]      pc_sel,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jump_target,
    input  logic [XLEN-1:0] ret_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] IF_ID_Inst,
    output logic [XLEN-1:0] IF_ID_PC,
    output logic            IF_ID_valid
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(1);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] ifpc_q, ifpc_d;
    logic            valid_q, valid_d;

    logic            redirect, xfer;
    logic [XLEN-1:0] target;
    logic            buf_load, buf_unload, buf_clear, buf_valid, buf_valid_nxt;
    logic [XLEN-1:0] buf_inst, buf_pc;

    fetch_skid_buffer #(.XLEN(XLEN)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .unload    (buf_unload),
        .clear     (buf_clear),
        .in_inst   (imem_rdata),
        .in_pc     (pc_q),
        .buf_inst  (buf_inst),
        .buf_pc    (buf_pc),
        .buf_valid (buf_valid)
    );

    always_comb begin
        redirect = is_redirect(branch_taken, pc_sel);
        xfer     = req_q && imem_ready;
        case (pc_sel)
            PCSEL_BR:  target = branch_target;
            PCSEL_JMP: target = jump_target;
            default:   target = ret_target;
        endcase

        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        ifpc_d     = ifpc_q;
        valid_d    = valid_q;
        buf_load   = 1'b0;
        buf_unload = 1'b0;
        buf_clear  = 1'b0;

        // Redirect always squashes IF/ID, whatever state the fetcher is in.
        if (redirect) begin
            pc_d    = target;
            inst_d  = XLEN'(NOP_INST);
            ifpc_d  = '0;
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (redirect) begin
                    buf_clear = 1'b1;
                    if (req_q && !imem_ready) state_d = ST_DRAIN;
                end else if (stall) begin
                    if (xfer) begin
                        buf_load = 1'b1;
                        pc_d     = pc_q + PC_STEP;
                    end
                end else if (buf_valid) begin
                    buf_unload = 1'b1;
                    inst_d     = buf_inst;
                    ifpc_d     = buf_pc;
                    valid_d    = 1'b1;
                end else if (xfer) begin
                    inst_d  = imem_rdata;
                    ifpc_d  = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + PC_STEP;
                end
            end
            ST_DRAIN: if (imem_ready) state_d = ST_FETCH;
            default:  state_d = ST_IDLE;
        endcase

        // Request and address are registered; a DRAIN keeps the orphan address stable.
        buf_valid_nxt = buf_load || (buf_valid && !buf_unload && !buf_clear);
        req_d  = ((state_d == ST_FETCH) && !buf_valid_nxt) || (state_d == ST_DRAIN);
        addr_d = (state_d == ST_DRAIN) ? addr_q : pc_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            inst_q  <= XLEN'(NOP_INST);
            ifpc_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            ifpc_q  <= ifpc_d;
            valid_q <= valid_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign IF_ID_Inst  = inst_q;
    assign IF_ID_PC    = ifpc_q;
    assign IF_ID_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized stall/redirect/ready traffic vs a reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, branch_taken, imem_ready;
    logic [1:0]  pc_sel;
    logic [15:0] branch_target, jump_target, ret_target;
    logic        imem_req, IF_ID_valid;
    logic [15:0] imem_addr, imem_rdata, IF_ID_Inst, IF_ID_PC;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'h1000 + a;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    fetch_unit #(.XLEN(16), .RESET_PC(16'h0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .pc_sel        (pc_sel),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .ret_target    (ret_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .IF_ID_Inst    (IF_ID_Inst),
        .IF_ID_PC      (IF_ID_PC),
        .IF_ID_valid   (IF_ID_valid)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode 0 = waiting one cycle after reset, 1 = fetching, 2 = draining an orphan.
    int          m_mode;
    logic [15:0] m_pc, m_orphan_addr;
    logic [15:0] m_inst, m_ifpc;
    logic        m_valid;
    logic [31:0] m_held[$];

    task automatic model_reset();
        m_mode = 0;
        m_pc = 16'h0000;
        m_orphan_addr = 16'h0000;
        m_inst = 16'h0000;
        m_ifpc = 16'h0000;
        m_valid = 1'b0;
        m_held.delete();
    endtask

    function automatic logic m_req();
        return (m_mode == 1 && m_held.size() == 0) || m_mode == 2;
    endfunction

    function automatic logic [15:0] m_addr();
        return (m_mode == 2) ? m_orphan_addr : m_pc;
    endfunction

    task automatic compare_all();
        chk("req",   16'(imem_req),    16'(m_req()));
        chk("addr",  imem_addr,        m_addr());
        chk("inst",  IF_ID_Inst,       m_inst);
        chk("ifpc",  IF_ID_PC,         m_ifpc);
        chk("valid", 16'(IF_ID_valid), 16'(m_valid));
    endtask

    // Called just after a falling edge: drive inputs, advance the model by one rising edge, then compare.
    task automatic cycle(input logic st, input logic bt, input logic [1:0] sel,
                         input logic [15:0] br, input logic [15:0] jmp, input logic [15:0] ret,
                         input logic rdy);
        logic        req, redir, took;
        logic [15:0] tgt;
        stall = st; branch_taken = bt; pc_sel = sel;
        branch_target = br; jump_target = jmp; ret_target = ret; imem_ready = rdy;

        req   = m_req();
        redir = bt && (sel != 2'b00);
        tgt   = (sel == 2'b01) ? br : (sel == 2'b10) ? jmp : ret;
        took  = req && rdy;
        if (m_mode == 0) begin
            if (redir) begin m_pc = tgt; m_inst = 0; m_ifpc = 0; m_valid = 0; end
            m_mode = 1;
        end else if (m_mode == 2) begin
            if (redir) begin m_pc = tgt; m_inst = 0; m_ifpc = 0; m_valid = 0; end
            if (rdy) m_mode = 1;
        end else if (redir) begin
            if (req && !rdy) begin m_mode = 2; m_orphan_addr = m_pc; end
            m_pc = tgt; m_inst = 0; m_ifpc = 0; m_valid = 0;
            m_held.delete();
        end else if (st) begin
            if (took) begin m_held.push_back({mem_word(m_pc), m_pc}); m_pc = m_pc + 1; end
        end else if (m_held.size() != 0) begin
            {m_inst, m_ifpc} = m_held.pop_front();
            m_valid = 1'b1;
        end else if (took) begin
            m_inst = mem_word(m_pc); m_ifpc = m_pc; m_valid = 1'b1; m_pc = m_pc + 1;
        end

        @(negedge clk);
        compare_all();
    endtask

    task automatic seq(input logic rdy);
        cycle(1'b0, 1'b0, 2'b00, 16'h0, 16'h0, 16'h0, rdy);
    endtask

    logic [15:0] held_addr;

    initial begin
        rst = 1'b1;
        stall = 0; branch_taken = 0; pc_sel = 0; imem_ready = 1;
        branch_target = 0; jump_target = 0; ret_target = 0;
        model_reset();
        @(negedge clk);
        chk("rst_req",   16'(imem_req), 16'h0);
        chk("rst_addr",  imem_addr, 16'h0000);
        chk("rst_valid", 16'(IF_ID_valid), 16'h0);
        chk("rst_inst",  IF_ID_Inst, 16'h0000);
        rst = 1'b0;

        // Zero-wait memory: one instruction per cycle after the IDLE cycle.
        seq(1'b1);
        chk("first_req_addr", imem_addr, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            seq(1'b1);
            chk("seq_inst", IF_ID_Inst, 16'h1000 + 16'(i));
            chk("seq_pc",   IF_ID_PC,   16'(i));
        end

        // Wait states hold the request.
        for (int i = 0; i < 3; i++) seq(1'b0);
        chk("wait_addr_hold", imem_addr, 16'h0003);
        seq(1'b1);
        chk("wait_done_inst", IF_ID_Inst, 16'h1003);

        // Stall with a landing word goes to the skid buffer, then replays in order.
        cycle(1'b1, 1'b0, 2'b00, 16'h0, 16'h0, 16'h0, 1'b1);
        chk("skid_req_low", 16'(imem_req), 16'h0);
        cycle(1'b1, 1'b0, 2'b00, 16'h0, 16'h0, 16'h0, 1'b1);
        seq(1'b1);
        chk("skid_release", IF_ID_Inst, 16'h1004);
        seq(1'b1);
        chk("skid_next", IF_ID_Inst, 16'h1005);

        // Jump beats a concurrent stall.
        cycle(1'b1, 1'b1, 2'b10, 16'h0, 16'h0040, 16'h0, 1'b1);
        chk("jmp_squash", 16'(IF_ID_valid), 16'h0);
        chk("jmp_addr", imem_addr, 16'h0040);
        seq(1'b1);
        chk("jmp_inst", IF_ID_Inst, 16'h1040);

        // Branch while a request waits: drain the orphan, then fetch the target.
        seq(1'b0);
        held_addr = m_addr();
        cycle(1'b0, 1'b1, 2'b01, 16'h0020, 16'h0, 16'h0, 1'b0);
        chk("drain_addr", imem_addr, held_addr);
        seq(1'b1);
        chk("drain_target", imem_addr, 16'h0020);
        chk("drain_discard", 16'(IF_ID_valid), 16'h0);

        // PC wraps modulo 2^16.
        cycle(1'b0, 1'b1, 2'b11, 16'h0, 16'h0, 16'hFFFF, 1'b1);
        seq(1'b1);
        chk("wrap_addr", imem_addr, 16'h0000);
        chk("wrap_ifpc", IF_ID_PC, 16'hFFFF);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, 2'($urandom),
                  16'($urandom), 16'($urandom), 16'($urandom), $urandom_range(0, 3) != 0);
        end

        // Reset in the middle of a wait: request drops at once.
        seq(1'b0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_req",   16'(imem_req), 16'h0);
        chk("midrst_addr",  imem_addr, 16'h0000);
        chk("midrst_valid", 16'(IF_ID_valid), 16'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        compare_all();
        seq(1'b1);
        chk("refetch_addr", imem_addr, 16'h0000);
        seq(1'b1);
        chk("refetch_inst", IF_ID_Inst, 16'h1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage of the 16-bit pipelined CPU. It is the producer end of the IF/ID interface: it owns the PC, issues requests to instruction memory over a req/ready handshake, and drives IF_ID_Inst and IF_ID_PC into the decoder. It honours stall from the hazard detector and redirect (pc_sel/branch_taken) from the branch controller, and squashes wrong-path instructions as NOP (16'h0000).

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
XLEN, 16, instruction and PC width (PC is word-addressed, increments by 1).

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  asynchronous active-high reset.
stall  in  1  hazard detector stall; IF/ID and PC hold.
branch_taken  in  1  redirect request from branch controller (EX).
pc_sel  in  2  00 sequential, 01 branch, 10 jump, 11 ret.
branch_target  in  16  target when pc_sel=01.
jump_target  in  16  target when pc_sel=10.
ret_target  in  16  target when pc_sel=11.
imem_req  out  1  fetch request.
imem_addr  out  16  fetch address (word).
imem_ready  in  1  memory accepts request; imem_rdata valid same cycle.
imem_rdata  in  16  instruction word.
IF_ID_Inst  out  16  instruction to decoder.
IF_ID_PC  out  16  PC of IF_ID_Inst.
IF_ID_valid  out  1  IF_ID_Inst is a real fetched instruction.

Behaviour:
- Reset (async, immediate): pc=RESET_PC, IF_ID_Inst=16'h0000, IF_ID_PC=16'h0000, IF_ID_valid=0, imem_req=0, imem_addr=RESET_PC, buf_valid=0, state=IDLE.
- States: IDLE (one cycle after reset release, req=0) -> FETCH. FETCH: imem_req=1 whenever buf_valid=0; imem_addr=pc. DRAIN: request in flight belongs to squashed path; req held, addr held; on imem_ready data discarded, go to FETCH.
- Handshake: once imem_req rises, imem_req and imem_addr stay stable until imem_ready; transfer = imem_req & imem_ready. Exactly one outstanding request. Zero-wait memory (ready tied 1) gives 1 instruction/cycle, 1-cycle latency from pc to IF_ID_Inst.
- Transfer without stall/redirect: IF_ID_Inst<=rdata, IF_ID_PC<=pc, IF_ID_valid<=1, pc<=pc+1.
- Transfer during stall: data captured in 1-entry skid buffer (buf_inst, buf_pc, buf_valid=1), pc<=pc+1; IF/ID holds. While buf_valid=1 imem_req=0.
- Stall released with buf_valid=1: IF/ID loads from buffer, buf_valid<=0; request for pc issues that same cycle.
- Stall, no transfer: IF/ID, pc hold; pending request stays asserted.
- Redirect (branch_taken=1 and pc_sel!=00): priority over stall. pc<=selected target; IF_ID_Inst<=16'h0000, IF_ID_valid<=0, IF_ID_PC<=0; buf_valid<=0. If a request is pending and not accepted this cycle -> DRAIN; if accepted this cycle its data is discarded, stay FETCH. First target fetch issues next cycle (2-cycle redirect penalty with zero-wait memory).
- branch_taken=1 with pc_sel=00: treated as no redirect. branch_taken=0: pc_sel ignored.
- Redirect while in DRAIN: target overwrites pc; stay DRAIN until old request accepted.
- PC arithmetic modulo 2^16: 16'hFFFF+1 = 16'h0000, no flag.
- Reset asserted mid-request: req drops immediately, in-flight data never written.

Decomposition:
- Shared package: NOP encoding 16'h0000, pc_sel encodings (PCSEL_SEQ/BR/JMP/RET), state encoding (IDLE/FETCH/DRAIN), opcode defines shared with decoder.
- One sub-module: fetch_skid_buffer (1-entry inst+pc holding register with load/unload/clear).

Test Plan:
- Reset, ready=1, memory[i]=16'h1000+i -> first req cycle 1 addr 0; IF_ID_Inst 1000,1001,1002 on consecutive cycles, IF_ID_PC 0,1,2, valid=1.
- ready=0 for 3 cycles at addr 5 -> imem_addr holds 5, req held, IF_ID_valid stays with prior inst; on ready=1 IF_ID_Inst=mem[5].
- stall=1 for 2 cycles while ready=1 -> one word (addr n) buffered, req low second cycle; on release IF_ID_Inst=mem[n], next cycle mem[n+1], no skip or duplicate.
- branch_taken=1, pc_sel=10, jump_target=16'h0040, concurrent stall=1 -> next IF_ID_Inst=0000 valid=0; then imem_addr=0040, IF_ID_Inst=mem[0x40].
- Redirect pc_sel=01 target 16'h0020 while request at addr 8 waiting (ready=0) -> DRAIN, addr stays 8; ready returns: mem[8] discarded, next req addr 0020.
- pc=16'hFFFF sequential fetch -> next imem_addr=16'h0000; rst pulsed mid-wait -> outputs at reset values same cycle, refetch from RESET_PC.
